// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// SCOREBOARD_FWD_EN selects forwarding (defined) or stall-on-any-match (undefined).
package pipe_pkg;

    localparam int RV_REG_IDX_W = 5;
    localparam int SEL_REGFILE  = 0;

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic                    valid;
        logic [RV_REG_IDX_W-1:0] rd;
        logic                    is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage operand/destination bundle and the scoreboard's hazard outputs.
interface pipe_scoreboard_if #(
    parameter int AW = 5,
    parameter int SW = 2
);
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_rs1_sel;
    logic [SW-1:0] fwd_rs2_sel;
    logic [31:0]   stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush,
        input  stall, fwd_rs1_sel, fwd_rs2_sel, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush,
        output stall, fwd_rs1_sel, fwd_rs2_sel, stall_cycles
    );
endinterface

// File: rtl/sb_operand_check.sv
// Per-operand hazard resolution against the tracked EX..WB destinations.
// Behaviour depends on SCOREBOARD_FWD_EN through pipe_pkg::FWD_EN.
module sb_operand_check
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = 2
) (
    input  sb_entry_t [DEPTH:1]        entries_i,
    input  logic                       id_valid_i,
    input  logic                       used_i,
    input  logic [RV_REG_IDX_W-1:0]    rs_i,
    output logic                       hazard_o,
    output logic [SW-1:0]              sel_o
);

    always_comb begin
        logic found;
        found    = 1'b0;
        hazard_o = 1'b0;
        sel_o    = SW'(SEL_REGFILE);
        // Ascending scan so the youngest (lowest stage) match is the one used.
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && id_valid_i && used_i && entries_i[k].valid &&
                (entries_i[k].rd != '0) && (entries_i[k].rd == rs_i)) begin
                found = 1'b1;
                if (!FWD_EN || (entries_i[k].is_load && (k < LOAD_STAGE)))
                    hazard_o = 1'b1;
                else
                    sel_o = SW'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Depth-generic RAW hazard scoreboard beside ID: stall request, forwarding selects, stall counter.
// Forwarding is built only when SCOREBOARD_FWD_EN is defined.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int  NREGS      = 32,
    parameter int  DEPTH      = 3,
    parameter int  LOAD_STAGE = 2,
    localparam int AW         = $clog2(NREGS),
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    pipe_scoreboard_if.slave sb
);

    if (DEPTH < 2 || LOAD_STAGE < 2 || LOAD_STAGE > DEPTH || AW > RV_REG_IDX_W) begin : g_param_check
        $error("pipe_scoreboard: illegal DEPTH/LOAD_STAGE/NREGS combination");
    end

    sb_entry_t [DEPTH:1]     ent_q, ent_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [RV_REG_IDX_W-1:0] rs1, rs2, rd;
    logic                    haz1, haz2, stall;

    assign rs1 = RV_REG_IDX_W'(sb.id_rs1);
    assign rs2 = RV_REG_IDX_W'(sb.id_rs2);
    assign rd  = RV_REG_IDX_W'(sb.id_rd);

    sb_operand_check #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)) u_chk_rs1 (
        .entries_i  (ent_q),
        .id_valid_i (sb.id_valid),
        .used_i     (sb.id_rs1_used),
        .rs_i       (rs1),
        .hazard_o   (haz1),
        .sel_o      (sb.fwd_rs1_sel)
    );

    sb_operand_check #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)) u_chk_rs2 (
        .entries_i  (ent_q),
        .id_valid_i (sb.id_valid),
        .used_i     (sb.id_rs2_used),
        .rs_i       (rs2),
        .hazard_o   (haz2),
        .sel_o      (sb.fwd_rs2_sel)
    );

    // Flush overrides stall: the killed instruction must not hold the front end.
    assign stall           = (haz1 | haz2) & sb.id_valid & ~sb.flush;
    assign sb.stall        = stall;
    assign sb.stall_cycles = cnt_q;

    always_comb begin
        ent_d = '0;
        for (int k = DEPTH; k >= 2; k--)
            ent_d[k] = ent_q[k-1];
        ent_d[1].valid   = sb.id_valid & sb.id_reg_write & ~stall & ~sb.flush;
        ent_d[1].rd      = rd;
        ent_d[1].is_load = sb.id_mem_read;
    end

    assign cnt_d = (stall && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed scoreboard bench for pipe_scoreboard (default parameters, either SCOREBOARD_FWD_EN setting).
module tb_pipe_scoreboard;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_scoreboard_if #(.AW(5), .SW(2)) sb_if ();

    pipe_scoreboard #(.NREGS(32), .DEPTH(3), .LOAD_STAGE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic idle();
        sb_if.id_valid     = 1'b0;
        sb_if.id_rs1       = '0;
        sb_if.id_rs2       = '0;
        sb_if.id_rs1_used  = 1'b0;
        sb_if.id_rs2_used  = 1'b0;
        sb_if.id_rd        = '0;
        sb_if.id_reg_write = 1'b0;
        sb_if.id_mem_read  = 1'b0;
        sb_if.flush        = 1'b0;
    endtask

    // Drive one ID instruction, push its expected outputs, then pop and compare
    // before the next rising edge. adv=0 leaves the bench mid-cycle.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld, input logic fl,
                        input logic e_stall, input logic [1:0] e_s1, input logic [1:0] e_s2,
                        input bit adv);
        exp_t e;
        sb_if.id_valid     = v;
        sb_if.id_rs1       = rs1;
        sb_if.id_rs1_used  = u1;
        sb_if.id_rs2       = rs2;
        sb_if.id_rs2_used  = u2;
        sb_if.id_rd        = rd;
        sb_if.id_reg_write = rw;
        sb_if.id_mem_read  = ld;
        sb_if.flush        = fl;
        e.tag = tag; e.stall = e_stall; e.s1 = e_s1; e.s2 = e_s2;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        chk({e.tag, ".stall"}, 32'(sb_if.stall), 32'(e.stall));
        chk({e.tag, ".sel1"}, 32'(sb_if.fwd_rs1_sel), 32'(e.s1));
        chk({e.tag, ".sel2"}, 32'(sb_if.fwd_rs2_sel), 32'(e.s2));
        chk({e.tag, ".cnt"}, sb_if.stall_cycles, 32'(exp_cnt));
        if (e.stall) exp_cnt++;
        if (adv) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        sb_if.id_valid = 1'b1; sb_if.id_rs1 = 5'd5; sb_if.id_rs1_used = 1'b1;
        #1;
        chk("rst.stall", 32'(sb_if.stall), 32'd0);
        chk("rst.sel1", 32'(sb_if.fwd_rs1_sel), 32'd0);
        chk("rst.cnt", sb_if.stall_cycles, 32'd0);
        idle();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        if (FWD) begin
            step("add_x5",    1, 0,0, 0,0, 5,1,0,0, 0,0,0, 1);
            step("rd_x5_ex",  1, 5,1, 1,1, 6,1,0,0, 0,1,0, 1);
            step("rd_x5_mem", 1, 7,1, 5,1, 0,0,0,0, 0,0,2, 1);
            step("rd_x5_wb",  1, 5,1, 6,0, 0,0,0,0, 0,3,0, 1);
            step("nop_valid", 0, 6,1, 0,0, 0,0,0,0, 0,0,0, 1);
            step("lw_x5",     1, 0,0, 0,0, 5,1,1,0, 0,0,0, 1);
            step("lu_stall",  1, 5,1, 5,1, 6,1,0,0, 1,0,0, 1);
            step("lu_fwd",    1, 5,1, 5,1, 6,1,0,0, 0,2,2, 1);
            step("add_x5_a",  1, 0,0, 0,0, 5,1,0,0, 0,0,0, 1);
            step("add_x5_b",  1, 0,0, 0,0, 5,1,0,0, 0,0,0, 1);
            step("youngest",  1, 5,1, 6,1, 0,0,0,0, 0,1,3, 1);
        end else begin
            step("add_x5",    1, 0,0, 0,0, 5,1,0,0, 0,0,0, 1);
            step("nf_stall1", 1, 5,1, 0,0, 6,1,0,0, 1,0,0, 1);
            step("nf_stall2", 1, 5,1, 0,0, 6,1,0,0, 1,0,0, 1);
            step("nf_stall3", 1, 5,1, 0,0, 6,1,0,0, 1,0,0, 1);
            step("nf_go",     1, 5,1, 0,0, 6,1,0,0, 0,0,0, 1);
        end

        step("wr_x0",     1, 0,0, 0,0, 0,1,0,0, 0,0,0, 1);
        step("rd_x0",     1, 0,1, 0,1, 0,0,0,0, 0,0,0, 1);
        step("lw_x7",     1, 0,0, 0,0, 7,1,1,0, 0,0,0, 1);
        step("flush_lu",  1, 7,1, 0,0, 8,1,0,1, 0,0,0, 1);
        step("post_flush",1, 8,1, 7,1, 0,0,0,0, !FWD, 0, FWD ? 2'd2 : 2'd0, 1);

        step("lw_x9",     1, 0,0, 0,0, 9,1,1,0, 0,0,0, 1);
        step("pre_rst",   1, 9,1, 0,0, 3,1,0,0, 1,0,0, 0);
        #1 reset = 1'b0;
        #1;
        chk("midrst.stall", 32'(sb_if.stall), 32'd0);
        chk("midrst.sel1", 32'(sb_if.fwd_rs1_sel), 32'd0);
        chk("midrst.cnt", sb_if.stall_cycles, 32'd0);
        exp_cnt = 0;
        idle();
        @(negedge clk) reset = 1'b1;
        step("rel_add_x5", 1, 0,0, 0,0, 5,1,0,0, 0,0,0, 1);
        step("rel_rd_x5",  1, 5,1, 0,0, 6,1,0,0, !FWD, FWD ? 2'd1 : 2'd0, 0, 1);

        idle();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
